// File: rtl/turn_signal_conditioner.sv
// Turn-switch input stage: 2-flop sync, per-channel debounce, press pulses,
// and the one-cycle step enable pacing the tail-light sequencer.
module turn_signal_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned STEP_DIV        = 25000000
) (
    input  logic clk,
    input  logic reset,
    input  logic left_in,
    input  logic right_in,
    output logic left,
    output logic right,
    output logic left_press,
    output logic right_press,
    output logic step
);

    localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned P_W  = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [P_W-1:0]  P_LAST  = P_W'(STEP_DIV - 1);

    // Channel index 0 is left, 1 is right.
    logic [1:0]      sync_meta;
    logic [1:0]      sync_s;
    logic [1:0]      deb;
    logic [1:0]      deb_q;
    logic [DB_W-1:0] c [2];
    logic [P_W-1:0]  p;
    logic [1:0]      press;
    logic            terminal;

    always_comb begin
        press    = deb & ~deb_q;
        terminal = (p == P_LAST);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_meta <= '0;
            sync_s    <= '0;
            deb       <= '0;
            deb_q     <= '0;
            c[0]      <= '0;
            c[1]      <= '0;
            p         <= '0;
        end else begin
            sync_meta <= {right_in, left_in};
            sync_s    <= sync_meta;
            deb_q     <= deb;
            for (int unsigned i = 0; i < 2; i++) begin
                if (sync_s[i] == deb[i]) begin
                    c[i] <= '0;
                end else if (c[i] == DB_LAST) begin
                    deb[i] <= sync_s[i];
                    c[i]   <= '0;
                end else begin
                    c[i] <= c[i] + 1'b1;
                end
            end
            // A press restarts the cadence and takes priority over the wrap.
            if ((|press) || terminal) begin
                p <= '0;
            end else begin
                p <= p + 1'b1;
            end
        end
    end

    assign left        = deb[0];
    assign right       = deb[1];
    assign left_press  = press[0];
    assign right_press = press[1];
    assign step        = terminal & ~(|press);

endmodule
